// File: rtl/fp_to_int.sv
// binary32 -> int32 converter, round-to-nearest-even.
// Bit-serial right alignment; valid/ready on both sides.
module fp_to_int (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] opd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        nan,
  output logic        overflow,
  output logic        inexact,
  output logic        zero
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ROUND,
    DONE
  } state_t;

  state_t state, state_nx;

  logic        s_q;
  logic [23:0] sh_q;
  logic        g_q;
  logic        st_q;
  logic [4:0]  cnt_q;
  logic        fin_q;

  logic        sgn;
  logic [7:0]  e;
  logic [22:0] mant;
  logic [23:0] sig;
  logic [7:0]  e_off;
  logic [7:0]  n8;
  logic [31:0] lmag;

  logic        is_nan;
  logic        is_big;
  logic        is_zero;
  logic        is_tiny;
  logic        is_left;
  logic        is_right;

  logic [31:0] c_res;
  logic        c_nan;
  logic        c_ovf;
  logic        c_inx;
  logic        c_zero;
  logic        c_fin;
  logic [4:0]  c_cnt;

  logic [24:0] rmag;
  logic [31:0] rres;

  assign sgn   = opd[31];
  assign e     = opd[30:23];
  assign mant  = opd[22:0];
  assign sig   = {1'b1, mant};
  assign e_off = e - 8'd150;
  assign n8    = 8'd150 - e;
  assign lmag  = {8'b0, sig} << e_off[2:0];

  assign is_nan   = (e == 8'd255) && (mant != 23'd0);
  assign is_big   = (e >= 8'd158) && !is_nan;
  assign is_zero  = (e == 8'd0) && (mant == 23'd0);
  assign is_tiny  = (e <= 8'd125) && !is_zero;
  assign is_left  = (e >= 8'd150) && (e <= 8'd157);
  assign is_right = (e >= 8'd126) && (e <= 8'd149);

  // Specials and exact left shifts resolve at acceptance and
  // pass through ROUND untouched (fin=1).
  always_comb begin
    c_res  = 32'd0;
    c_nan  = 1'b0;
    c_ovf  = 1'b0;
    c_inx  = 1'b0;
    c_zero = 1'b0;
    c_fin  = 1'b1;
    c_cnt  = 5'd0;
    unique case (1'b1)
      is_nan: begin
        c_res = 32'h8000_0000;
        c_nan = 1'b1;
      end
      is_big: begin
        if (sgn && (e == 8'd158) && (mant == 23'd0)) begin
          c_res = 32'h8000_0000;
        end else begin
          c_res = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
          c_ovf = 1'b1;
        end
      end
      is_zero: begin
        c_zero = 1'b1;
      end
      is_tiny: begin
        c_zero = 1'b1;
        c_inx  = 1'b1;
      end
      is_left: begin
        c_res = sgn ? -lmag : lmag;
      end
      is_right: begin
        c_fin = 1'b0;
        c_cnt = n8[4:0];
      end
      default: ;
    endcase
  end

  assign rmag = {1'b0, sh_q}
              + {24'd0, g_q & (st_q | sh_q[0])};
  assign rres = s_q ? -{7'd0, rmag} : {7'd0, rmag};

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (in_valid) state_nx = c_fin ? ROUND : SHIFT;
      SHIFT: if (cnt_q == 5'd1) state_nx = ROUND;
      ROUND: state_nx = DONE;
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      s_q      <= 1'b0;
      sh_q     <= 24'd0;
      g_q      <= 1'b0;
      st_q     <= 1'b0;
      cnt_q    <= 5'd0;
      fin_q    <= 1'b0;
      res      <= 32'd0;
      nan      <= 1'b0;
      overflow <= 1'b0;
      inexact  <= 1'b0;
      zero     <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            s_q      <= sgn;
            sh_q     <= sig;
            g_q      <= 1'b0;
            st_q     <= 1'b0;
            cnt_q    <= c_cnt;
            fin_q    <= c_fin;
            res      <= c_res;
            nan      <= c_nan;
            overflow <= c_ovf;
            inexact  <= c_inx;
            zero     <= c_zero;
          end
        end
        SHIFT: begin
          st_q  <= st_q | g_q;
          g_q   <= sh_q[0];
          sh_q  <= sh_q >> 1;
          cnt_q <= cnt_q - 5'd1;
        end
        ROUND: begin
          if (!fin_q) begin
            res     <= rres;
            inexact <= g_q | st_q;
            zero    <= (rmag == 25'd0);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule
